// File: rtl/dcmac_0_pkg.sv
// Shared types for the dcmac_0 statistics read path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: FSM state encoding of the stats controller and the response record.
package dcmac_0_pkg;

    // Wide enough for any practical channel count; users slice to their ID width.
    localparam int RSP_ID_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RSP    = 2'd3
    } stats_state_e;

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [63:0]         pkt;
        logic [63:0]         byte_cnt;
    } stats_rsp_t;

endpackage

// File: rtl/dcmac_0_stats_ext_bank.sv
// Per-ID 32-bit upper-word extension of the hardware packet/byte counters.
// Latency: a carry is reflected in the extension one cycle later.
// Backpressure: none; carries are never dropped, a clear of the same ID wins.
// Ports: clk/rst; carry_id_i, pkt_carry_i, byte_carry_i (carry strobe and owner);
//        clr_en_i/clr_id_i (zero one ID); ext_pkt_o/ext_byte_o (all extension words).
module dcmac_0_stats_ext_bank #(
    parameter  int NUM_ID = 6,
    localparam int ID_W   = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ID_W-1:0]          carry_id_i,
    input  logic                     pkt_carry_i,
    input  logic                     byte_carry_i,
    input  logic                     clr_en_i,
    input  logic [ID_W-1:0]          clr_id_i,
    output logic [NUM_ID-1:0][31:0]  ext_pkt_o,
    output logic [NUM_ID-1:0][31:0]  ext_byte_o
);

    logic [NUM_ID-1:0][31:0] ext_pkt_q,  ext_pkt_d;
    logic [NUM_ID-1:0][31:0] ext_byte_q, ext_byte_d;

    always_comb begin
        ext_pkt_d  = ext_pkt_q;
        ext_byte_d = ext_byte_q;
        for (int i = 0; i < NUM_ID; i++) begin
            // The clearing ID's carry is folded into the hold value by the
            // controller, so zeroing here must not also count it.
            if (clr_en_i && (clr_id_i == ID_W'(i))) begin
                ext_pkt_d[i]  = '0;
                ext_byte_d[i] = '0;
            end else if (carry_id_i == ID_W'(i)) begin
                ext_pkt_d[i]  = ext_pkt_q[i]  + {31'b0, pkt_carry_i};
                ext_byte_d[i] = ext_byte_q[i] + {31'b0, byte_carry_i};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pkt_q  <= '0;
            ext_byte_q <= '0;
        end else begin
            ext_pkt_q  <= ext_pkt_d;
            ext_byte_q <= ext_byte_d;
        end
    end

    assign ext_pkt_o  = ext_pkt_q;
    assign ext_byte_o = ext_byte_q;

endmodule

// File: rtl/dcmac_0_axis_stats_ctrl.sv
// Clear-on-read controller returning 64-bit packet/byte counts per ID.
// Latency: SETTLE_CYC+2 cycles from request to response with i_rsp_ready high.
// Backpressure: one read in flight; o_req_ready low until the response is taken.
// Ports: clk/rst; i_req_valid/o_req_ready/i_req_id (read request);
//        o_clear_counters (per-ID clear level); i_pkt_cnt/i_byte_cnt (low-word snapshots);
//        i_carry_id_m1/i_pkt_cnt_carry/i_byte_cnt_carry (overflow strobes);
//        o_rsp_valid/i_rsp_ready/o_rsp_id/o_rsp_pkt/o_rsp_byte (response).
module dcmac_0_axis_stats_ctrl
    import dcmac_0_pkg::*;
#(
    parameter  int NUM_ID     = 6,
    parameter  int SETTLE_CYC = 16,
    localparam int ID_W       = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [ID_W-1:0]         i_req_id,
    output logic [NUM_ID-1:0]       o_clear_counters,
    input  logic [NUM_ID-1:0][31:0] i_pkt_cnt,
    input  logic [NUM_ID-1:0][31:0] i_byte_cnt,
    input  logic [ID_W-1:0]         i_carry_id_m1,
    input  logic                    i_pkt_cnt_carry,
    input  logic                    i_byte_cnt_carry,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [63:0]             o_rsp_pkt,
    output logic [63:0]             o_rsp_byte
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [ID_W:0] NUM_ID_V = (ID_W + 1)'(NUM_ID);

    stats_state_e             state_q, state_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic                     id_ok_q, id_ok_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [31:0]              hold_pkt_q, hold_pkt_d;
    logic [31:0]              hold_byte_q, hold_byte_d;
    logic [NUM_ID-1:0]        clr_q, clr_d;
    stats_rsp_t               rsp_q, rsp_d;
    logic                     rsp_vld_q, rsp_vld_d;

    logic                     ext_clr;
    logic                     req_in_range;
    logic                     carry_hit;
    logic [NUM_ID-1:0][31:0]  ext_pkt;
    logic [NUM_ID-1:0][31:0]  ext_byte;
    logic                     unused_rsp_id;

    dcmac_0_stats_ext_bank #(
        .NUM_ID (NUM_ID)
    ) u_ext_bank (
        .clk          (clk),
        .rst          (rst),
        .carry_id_i   (i_carry_id_m1),
        .pkt_carry_i  (i_pkt_cnt_carry),
        .byte_carry_i (i_byte_cnt_carry),
        .clr_en_i     (ext_clr),
        .clr_id_i     (id_q),
        .ext_pkt_o    (ext_pkt),
        .ext_byte_o   (ext_byte)
    );

    assign req_in_range = ({1'b0, i_req_id} < NUM_ID_V);
    assign carry_hit    = (i_carry_id_m1 == id_q);

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        id_ok_d     = id_ok_q;
        cnt_d       = cnt_q;
        hold_pkt_d  = hold_pkt_q;
        hold_byte_d = hold_byte_q;
        clr_d       = clr_q;
        rsp_d       = rsp_q;
        rsp_vld_d   = rsp_vld_q;
        ext_clr     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clr_d = '0;
                if (i_req_valid) begin
                    state_d = ST_CLEAR;
                    id_d    = i_req_id;
                    id_ok_d = req_in_range;
                    // Out-of-range IDs never touch the counters.
                    if (req_in_range) begin
                        clr_d[i_req_id] = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
                if (id_ok_q) begin
                    // Close the epoch: a carry landing this cycle belongs to it.
                    ext_clr     = 1'b1;
                    hold_pkt_d  = ext_pkt[id_q]  + {31'b0, i_pkt_cnt_carry  & carry_hit};
                    hold_byte_d = ext_byte[id_q] + {31'b0, i_byte_cnt_carry & carry_hit};
                end else begin
                    hold_pkt_d  = '0;
                    hold_byte_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d      = ST_RSP;
                    clr_d        = '0;
                    rsp_vld_d    = 1'b1;
                    rsp_d.id     = RSP_ID_W'(id_q);
                    rsp_d.pkt      = id_ok_q ? {hold_pkt_q,  i_pkt_cnt[id_q]}  : 64'd0;
                    rsp_d.byte_cnt = id_ok_q ? {hold_byte_q, i_byte_cnt[id_q]} : 64'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            id_ok_q     <= 1'b0;
            cnt_q       <= '0;
            hold_pkt_q  <= '0;
            hold_byte_q <= '0;
            clr_q       <= '0;
            rsp_q       <= '0;
            rsp_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            id_ok_q     <= id_ok_d;
            cnt_q       <= cnt_d;
            hold_pkt_q  <= hold_pkt_d;
            hold_byte_q <= hold_byte_d;
            clr_q       <= clr_d;
            rsp_q       <= rsp_d;
            rsp_vld_q   <= rsp_vld_d;
        end
    end

    assign o_req_ready      = (state_q == ST_IDLE);
    assign o_clear_counters = clr_q;
    assign o_rsp_valid      = rsp_vld_q;
    assign o_rsp_id         = rsp_q.id[ID_W-1:0];
    assign o_rsp_pkt        = rsp_q.pkt;
    assign o_rsp_byte       = rsp_q.byte_cnt;
    assign unused_rsp_id    = ^rsp_q.id;

endmodule

// File: tb/tb_dcmac_0_axis_stats_ctrl.sv
// Randomised scoreboard bench for the clear-on-read stats controller.
// Latency: checks request-to-response latency and clear pulse widths.
// Backpressure: exercises i_rsp_ready stalls and reset aborts.
module tb_dcmac_0_axis_stats_ctrl;

    localparam int NUM_ID = 6;
    localparam int S      = 16;
    localparam int ID_W   = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    i_req_valid;
    logic                    o_req_ready;
    logic [ID_W-1:0]         i_req_id;
    logic [NUM_ID-1:0]       o_clear_counters;
    logic [NUM_ID-1:0][31:0] i_pkt_cnt;
    logic [NUM_ID-1:0][31:0] i_byte_cnt;
    logic [ID_W-1:0]         i_carry_id_m1;
    logic                    i_pkt_cnt_carry;
    logic                    i_byte_cnt_carry;
    logic                    o_rsp_valid;
    logic                    i_rsp_ready;
    logic [ID_W-1:0]         o_rsp_id;
    logic [63:0]             o_rsp_pkt;
    logic [63:0]             o_rsp_byte;

    dcmac_0_axis_stats_ctrl #(.NUM_ID(NUM_ID), .SETTLE_CYC(S)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_id         (i_req_id),
        .o_clear_counters (o_clear_counters),
        .i_pkt_cnt        (i_pkt_cnt),
        .i_byte_cnt       (i_byte_cnt),
        .i_carry_id_m1    (i_carry_id_m1),
        .i_pkt_cnt_carry  (i_pkt_cnt_carry),
        .i_byte_cnt_carry (i_byte_cnt_carry),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (i_rsp_ready),
        .o_rsp_id         (o_rsp_id),
        .o_rsp_pkt        (o_rsp_pkt),
        .o_rsp_byte       (o_rsp_byte)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        int          id;
        logic [63:0] pkt;
        logic [63:0] byt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          in_rsp;
    int          run[NUM_ID];
    int          cyc;
    int          n_chk;
    int          n_fail;
    // Reference model: carries seen per ID since that ID's epoch was last closed.
    int unsigned m_pkt[NUM_ID];
    int unsigned m_byte[NUM_ID];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: protocol rules plus scoreboard pop on every presented response.
    always @(negedge clk) begin
        if (rst) begin
            in_rsp = 1'b0;
            for (int i = 0; i < NUM_ID; i++) run[i] = 0;
        end else begin
            check("clear_onehot0", 64'($onehot0(o_clear_counters)), 64'd1);
            if (o_req_ready) check("clear_zero_idle", 64'(o_clear_counters), 64'd0);
            for (int i = 0; i < NUM_ID; i++) begin
                if (o_clear_counters[i]) begin
                    run[i]++;
                end else if (run[i] != 0) begin
                    check("clear_pulse_len", 64'(run[i]), 64'(S + 1));
                    run[i] = 0;
                end
            end
            if (o_rsp_valid) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 64'd1, 64'd0);
                        cur = '{acc: cyc - S - 2, id: 0, pkt: 64'd0, byt: 64'd0};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    check("rsp_id", 64'(o_rsp_id), 64'(cur.id));
                    check("rsp_pkt", o_rsp_pkt, cur.pkt);
                    check("rsp_byte", o_rsp_byte, cur.byt);
                    check("rsp_latency", 64'(cyc - cur.acc), 64'(S + 2));
                end else begin
                    check("stall_pkt_stable", o_rsp_pkt, cur.pkt);
                    check("stall_byte_stable", o_rsp_byte, cur.byt);
                    check("stall_req_ready", 64'(o_req_ready), 64'd0);
                end
                in_rsp = !i_rsp_ready;
            end
        end
    end

    // One clock of stimulus with the given carry; the model counts it immediately.
    task automatic step(input int cid, input bit pc, input bit bc);
        i_carry_id_m1    = ID_W'(cid);
        i_pkt_cnt_carry  = pc;
        i_byte_cnt_carry = bc;
        if (pc) m_pkt[cid]++;
        if (bc) m_byte[cid]++;
        @(posedge clk);
        #1;
        i_pkt_cnt_carry  = 1'b0;
        i_byte_cnt_carry = 1'b0;
    endtask

    // Carry plan: 0 none, 1 random, 2 active-ID carry in the clear cycle,
    // 3 active-ID carry in the first settle cycle.
    task automatic plan(input int mode, input int k, input int id,
                        output int cid, output bit pc, output bit bc);
        cid = 0; pc = 1'b0; bc = 1'b0;
        if (mode == 1) begin
            cid = $urandom_range(0, NUM_ID - 1);
            pc  = ($urandom_range(0, 3) == 0);
            bc  = ($urandom_range(0, 2) == 0);
        end else if (((mode == 2 && k == 1) || (mode == 3 && k == 2)) && id < NUM_ID) begin
            cid = id; pc = 1'b1; bc = 1'b1;
        end
    endtask

    task automatic do_read(input int id, input logic [31:0] ps, input logic [31:0] bs,
                           input int mode, input int stall, input int abort_at);
        exp_t e;
        bit   inr;
        int   cid, g;
        bit   pc, bc;
        inr = (id < NUM_ID);
        g = 0;
        while (!o_req_ready && g < 50) begin step(0, 0, 0); g++; end
        check("req_ready_idle", 64'(o_req_ready), 64'd1);
        for (int i = 0; i < NUM_ID; i++) begin
            i_pkt_cnt[i]  = $urandom;
            i_byte_cnt[i] = $urandom;
        end
        if (inr) begin i_pkt_cnt[id] = ps; i_byte_cnt[id] = bs; end
        i_rsp_ready = (stall == 0);
        i_req_valid = 1'b1;
        i_req_id    = ID_W'(id);
        e.acc = cyc;
        e.id  = id;
        for (int k = 0; k < S + 2; k++) begin
            plan(mode, k, id, cid, pc, bc);
            step(cid, pc, bc);
            i_req_valid = 1'b0;
            if (k == 1) begin
                // Epoch closes here: everything counted so far is the upper word.
                if (inr) begin
                    e.pkt = {m_pkt[id], ps};
                    e.byt = {m_byte[id], bs};
                    m_pkt[id]  = 0;
                    m_byte[id] = 0;
                end else begin
                    e.pkt = 64'd0;
                    e.byt = 64'd0;
                end
                exp_q.push_back(e);
                check("clear_level", 64'(o_clear_counters), inr ? (64'd1 << id) : 64'd0);
            end
            if (abort_at > 1 && k == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_clear_now", 64'(o_clear_counters), 64'd0);
                check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
                i_rsp_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                for (int i = 0; i < NUM_ID; i++) begin m_pkt[i] = 0; m_byte[i] = 0; end
                void'(exp_q.pop_back());
                check("rst_req_ready", 64'(o_req_ready), 64'd1);
                repeat (S + 4) step(0, 0, 0);
                return;
            end
        end
        for (int k = 0; k < stall; k++) begin
            plan(mode, 99, id, cid, pc, bc);
            step(cid, pc, bc);
        end
        i_rsp_ready = 1'b1;
        g = 0;
        while (o_rsp_valid && g < 10) begin
            plan(mode, 99, id, cid, pc, bc);
            step(cid, pc, bc);
            g++;
        end
        check("rsp_consumed", 64'(o_rsp_valid), 64'd0);
    endtask

    initial begin
        int g;
        n_chk = 0; n_fail = 0; cyc = 0; in_rsp = 1'b0;
        for (int i = 0; i < NUM_ID; i++) begin m_pkt[i] = 0; m_byte[i] = 0; run[i] = 0; end
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_id = '0; i_pkt_cnt = '0; i_byte_cnt = '0;
        i_carry_id_m1 = '0; i_pkt_cnt_carry = 1'b0; i_byte_cnt_carry = 1'b0;
        i_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_clear", 64'(o_clear_counters), 64'd0);
        check("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_req_ready", 64'(o_req_ready), 64'd1);
        check("reset_rsp_id", 64'(o_rsp_id), 64'd0);
        check("reset_rsp_pkt", o_rsp_pkt, 64'd0);
        check("reset_rsp_byte", o_rsp_byte, 64'd0);

        // Plain read, no carries.
        do_read(2, 32'd100, 32'd6400, 0, 0, 0);
        // Three byte carries on ID 1, then two reads.
        repeat (3) step(1, 0, 1);
        do_read(1, 32'd7, 32'd5, 0, 0, 0);
        do_read(1, 32'd7, 32'd5, 0, 0, 0);
        // Carry in the clear cycle vs. in settle.
        do_read(3, 32'd11, 32'd22, 2, 0, 0);
        do_read(3, 32'd11, 32'd22, 3, 0, 0);
        do_read(3, 32'd11, 32'd22, 0, 0, 0);
        // Long response stall.
        do_read(4, 32'hdead_beef, 32'h1234_5678, 0, 10, 0);
        // Back-to-back reads of the two edge IDs.
        do_read(0, 32'd1, 32'd2, 0, 0, 0);
        do_read(5, 32'd3, 32'd4, 0, 0, 0);
        // Out-of-range IDs leave extension state alone.
        step(5, 1, 1);
        do_read(6, 32'd9, 32'd9, 0, 0, 0);
        do_read(7, 32'd9, 32'd9, 0, 1, 0);
        do_read(5, 32'd8, 32'd8, 0, 0, 0);
        // Reset mid-settle with pending extension counts.
        step(2, 1, 1);
        step(4, 0, 1);
        do_read(2, 32'd50, 32'd60, 0, 0, 5);
        do_read(2, 32'd51, 32'd61, 0, 0, 0);
        do_read(4, 32'd52, 32'd62, 0, 0, 0);
        // Randomised traffic.
        for (int t = 0; t < 30; t++) begin
            do_read($urandom_range(0, 7), $urandom, $urandom, 1,
                    $urandom_range(0, 3), 0);
        end
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin step(0, 0, 0); g++; end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dcmac_0_axis_stats_ctrl.md
DCMAC_0_AXIS_STATS_CTRL -- requirements
Module: dcmac_0_axis_stats_ctrl

Interface
REQ-001 Parameter NUM_ID, default 6: number of counter IDs (channels).
REQ-002 Parameter SETTLE_CYC, default 16: cycles waited after a clear edge before sampling the snapshot (must be at least NUM_ID+4).
REQ-003 Localparam ID_W = 1 if NUM_ID==1, else clog2(NUM_ID).
REQ-004 Port clk, input, 1: the single clock for the block.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port i_req_valid, input, 1: software read request valid.
REQ-007 Port o_req_ready, output, 1: request accepted when valid and ready are both high.
REQ-008 Port i_req_id, input, ID_W: ID to read.
REQ-009 Port o_clear_counters, output, NUM_ID: per-ID clear level driven to the packet counter.
REQ-010 Port i_pkt_cnt, input, NUM_ID x 32: packet count snapshots from the counter.
REQ-011 Port i_byte_cnt, input, NUM_ID x 32: byte count snapshots from the counter.
REQ-012 Port i_carry_id_m1, input, ID_W: ID owning the carry bits in the same cycle.
REQ-013 Port i_pkt_cnt_carry, input, 1: packet counter 32-bit overflow for i_carry_id_m1.
REQ-014 Port i_byte_cnt_carry, input, 1: byte counter 32-bit overflow for i_carry_id_m1.
REQ-015 Port o_rsp_valid, output, 1: response valid.
REQ-016 Port i_rsp_ready, input, 1: response consumed when valid and ready are both high.
REQ-017 Port o_rsp_id, output, ID_W: ID of the response.
REQ-018 Port o_rsp_pkt, output, 64: packet count of the closed epoch.
REQ-019 Port o_rsp_byte, output, 64: byte count of the closed epoch.

Function
REQ-020 Per-ID 32-bit extension registers ext_pkt[i] and ext_byte[i] SHALL increment (mod 2^32) in the cycle after a carry with i_carry_id_m1==i.
REQ-021 The FSM SHALL have states IDLE, CLEAR, SETTLE, RSP.
REQ-022 In IDLE, o_req_ready SHALL be 1 and all other states SHALL drive it 0.
REQ-023 On request acceptance, the FSM SHALL latch the ID and go to CLEAR.
REQ-024 A request with i_req_id >= NUM_ID SHALL be accepted and answered with zero counts, o_clear_counters unchanged, and ext untouched.
REQ-025 CLEAR SHALL last exactly 1 cycle: o_clear_counters[id] SHALL rise, the current ext[id] pair SHALL be moved to hold registers, and ext[id] SHALL be zeroed.
REQ-026 A carry for id arriving in the CLEAR cycle SHALL be added to the hold value, not to ext.
REQ-027 SETTLE SHALL keep o_clear_counters[id] high for SETTLE_CYC cycles, then drop it and go to RSP.
REQ-028 Carries for id during SETTLE SHALL be counted into ext (new epoch).
REQ-029 On RSP entry, o_rsp_pkt SHALL equal {hold_pkt, i_pkt_cnt[id]} and o_rsp_byte SHALL equal {hold_byte, i_byte_cnt[id]}, registered.
REQ-030 o_rsp_valid SHALL then stay high with stable data until i_rsp_ready, after which the FSM returns to IDLE.
REQ-031 Request-to-response latency SHALL be exactly SETTLE_CYC+2 cycles when i_rsp_ready is held high.
REQ-032 o_clear_counters SHALL be one-hot or zero, and SHALL be 0 in IDLE and RSP, guaranteeing a fresh rising edge per read.
REQ-033 Carries for IDs other than the active ID SHALL always update ext regardless of FSM state.

Reset
REQ-034 Asserting rst SHALL asynchronously force: FSM to IDLE, o_req_ready=1 after release, o_clear_counters=0, o_rsp_valid=0, o_rsp_id/o_rsp_pkt/o_rsp_byte=0, all ext and hold registers=0.
REQ-035 Reset during SETTLE or RSP SHALL abandon the transaction with no response.

Structure
REQ-036 FSM state enum and the response record type (id, pkt64, byte64) SHALL live in the shared dcmac_0 package.
REQ-037 The per-ID extension register array SHALL be the sub-module dcmac_0_stats_ext_bank, parameterised by NUM_ID.

Verification
REQ-038 Read of ID 2 with snapshot 100/6400 and no carries -> rsp pkt=100, byte=6400 at cycle SETTLE_CYC+2.
REQ-039 Three byte carries on ID 1 then a read with snapshot 5 -> rsp byte=0x0000_0003_0000_0005, and a second read -> upper word 0.
REQ-040 Carry for the active ID in the CLEAR cycle -> counted in the current response; carry in SETTLE -> appears in the next read only.
REQ-041 i_rsp_ready held low 10 cycles -> o_rsp_valid and data stable, o_req_ready=0 throughout.
REQ-042 rst asserted mid-SETTLE -> o_clear_counters=0 immediately, no o_rsp_valid, ext all zero.
REQ-043 Back-to-back reads of ID 0 then ID 5 -> each o_clear_counters bit pulses high for SETTLE_CYC+1 cycles with a separate rising edge each.
